stream_mux_arb: RTL
===================

# stream_mux_arb

Parametrised N-to-1 data multiplexer with valid/ready handshakes and a registered output stage. It replaces the fixed 2-to-1 select mux wherever several producers share one consumer. Two selection modes: round-robin arbitration among valid inputs, or forced selection by an explicit `sel` input (the classic mux behaviour). It sits between the channel producers and a single downstream stage, giving one beat per cycle of throughput.

## Interface
- `N`, 4: number of input channels, at least 2.
- `WIDTH`, 8: data width per channel, at least 1.
- `SELW`, `$clog2(N)`: derived channel-index width; not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = round-robin arbitration; 1 = forced select.
- `sel`  in  SELW  channel index used when `mode`=1.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; at most one bit high.
- `out_data`  out  WIDTH  registered data.
- `out_chan`  out  SELW  source channel of `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts.

## Operation
- Load enable: `ld = !out_valid | out_ready`.
- Grant, combinational:
  - `mode`=0: first i with `in_valid[i]`=1, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - `mode`=1: `g = sel` if `sel < N` and `in_valid[sel]`=1; otherwise no grant.
- `in_ready[g] = ld` for the granted channel only. All other bits are 0. All bits are 0 when there is no grant.
- Input transfer on channel g: `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- Output transfer: `out_valid & out_ready`. If `ld`=1 and there is no grant, `out_valid <= 0` and `out_data`/`out_chan` hold.
- If `ld`=0, the output register holds all fields.
- Round-robin pointer `ptr` (SELW bits):
  - After a transfer in `mode`=0, `ptr <= (g == N-1) ? 0 : g+1`.
  - `ptr` does not change in `mode`=1 or on idle cycles.
- A change on `mode` or `sel` affects only the next grant decision. A beat already held is never altered or dropped.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_data` to any output.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0. `in_ready` is all-zero during reset.
- Latency: an input accepted at edge k appears on `out_*` after edge k, i.e. one cycle.
- Throughput: one beat per cycle while `out_ready`=1 and some valid input is granted.
- Simultaneous accept and drain (output full, `out_ready`=1, grant present): the old beat leaves and the new beat loads on the same edge, with no bubble.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and the register is stable.
- Wrap-around: with `ptr`=N-1, the scan continues at 0.
- Reset asserted mid-operation: outputs clear immediately (asynchronously) and any held beat is discarded. After deassertion the first arbitration starts at channel 0.

## Structure
- Shared package `stream_mux_pkg`:
  - mode constants `MODE_RR`=1'b0, `MODE_SEL`=1'b1;
  - a function returning `$clog2` with a minimum of 1.
- Sub-module `rr_grant`:
  - inputs: request vector, pointer, mode, sel;
  - outputs: grant-valid and grant index;
  - purely combinational, parametrised on N.
- The top level holds the output register, the pointer register and the ready generation.

## Test plan
- N=4, WIDTH=8, `mode`=0, `out_ready`=1, all valid, data 8'hA0+i -> `out_data` sequence A0,A1,A2,A3,A0 on consecutive cycles, `out_chan` 0,1,2,3,0.
- `mode`=0, only channels 1 and 3 valid, `ptr`=2 -> grant 3 first, then 1. `ptr` becomes 0, then 2.
- `mode`=1, `sel`=2, channels 0–3 valid -> only `in_ready[2]`=1 and `out_chan`=2 every beat. `sel`=2 with `in_valid[2]`=0 -> `out_valid` drops to 0 after the drain.
- Hold `out_ready`=0 for 3 cycles with a beat loaded (55) -> `out_data`=55 stable, `in_ready`=0. Release -> 55 drains and the next beat loads on the same edge.
- Assert `rst` asynchronously mid-stream, between edges -> `out_valid`=0, `out_data`=0, `out_chan`=0 immediately. After release with all valid -> first `out_chan`=0.
- N=3 with `mode`=1, `sel`=3 (out of range) -> no grant, `in_ready`=0, `out_valid` stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer/arbiter.
package stream_mux_pkg;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_SEL = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selection: round-robin from a pointer, or forced by sel.
module rr_grant
   import stream_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = clog2_min1(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   // Two-pass scan: first requests at or above ptr, then wrap to the lowest one.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (mode == MODE_SEL) begin
         // Out-of-range sel matches no channel and yields no grant.
         for (int i = 0; i < N; i++) begin
            if (!gnt_valid && req[i] && (int'(sel) == i)) begin
               gnt_valid = 1'b1;
               gnt_idx   = SELW'(i);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!gnt_valid && req[i] && (i >= int'(ptr))) begin
               gnt_valid = 1'b1;
               gnt_idx   = SELW'(i);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!gnt_valid && req[i]) begin
               gnt_valid = 1'b1;
               gnt_idx   = SELW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with round-robin or forced selection and a
// registered output stage sustaining one beat per cycle.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = clog2_min1(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   logic            ld;
   logic            gnt_valid;
   logic [SELW-1:0] gnt_idx;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_next;
   logic [WIDTH-1:0] gnt_data;

   assign ld       = !out_valid || out_ready;
   assign ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);

   rr_grant #(
      .N    (N),
      .SELW (SELW)
   ) u_grant (
      .req       (in_valid),
      .ptr       (ptr),
      .mode      (mode),
      .sel       (sel),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Ready goes to the granted channel only; held low while reset is asserted.
   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_valid && (int'(gnt_idx) == i)) begin
            in_ready[i] = ld && !rst;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register and round-robin pointer; load, drain-to-empty or hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (ld) begin
         if (gnt_valid) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_chan  <= gnt_idx;
            if (mode == MODE_RR) begin
               ptr <= ptr_next;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
